// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte/half/word little-endian access, load
// extension, access-error flagging and a fixed response latency.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       LAT_ONE  = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                access_s;

  logic                we_r, uns_r;
  logic [31:0]         addr_r, wdata_r;
  logic [1:0]          size_r;

  logic                eff_we_s, eff_uns_s;
  logic [31:0]         eff_addr_s, eff_wdata_s;
  logic [1:0]          eff_size_s;
  logic                err_s;
  logic [ADDR_W-1:0]   idx_s;
  logic [31:0]         word_s, rdata_s, merged_s;

  logic                req_ready_r, resp_valid_r, resp_err_r;
  logic [31:0]         resp_rdata_r;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  function automatic logic access_error(input logic [31:0] addr, input logic [1:0] size);
    logic e;
    case (size)
      2'd0:    e = 1'b0;
      2'd1:    e = addr[0];
      2'd2:    e = (addr[1:0] != 2'b00);
      default: e = 1'b1;
    endcase
    return e | ((addr >> (ADDR_W + 2)) != 32'd0);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] m;
    logic [31:0] d;
    case (size)
      2'd0: begin
        m = 32'h0000_00FF << {lane, 3'b000};
        d = {4{wdata[7:0]}};
      end
      2'd1: begin
        m = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        d = {2{wdata[15:0]}};
      end
      default: begin
        m = 32'hFFFF_FFFF;
        d = wdata;
      end
    endcase
    return (word & ~m) | (d & m);
  endfunction

  // Select live inputs on the accept edge (single-cycle latency) or the latched request later
  always_comb begin
    if (state_r == IDLE) begin
      eff_we_s    = bus.req_we;
      eff_addr_s  = bus.req_addr;
      eff_wdata_s = bus.req_wdata;
      eff_size_s  = bus.req_size;
      eff_uns_s   = bus.req_unsigned;
    end else begin
      eff_we_s    = we_r;
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
      eff_size_s  = size_r;
      eff_uns_s   = uns_r;
    end
    err_s    = access_error(eff_addr_s, eff_size_s);
    idx_s    = eff_addr_s[ADDR_W+1:2];
    word_s   = mem[idx_s];
    rdata_s  = load_extract(word_s, eff_addr_s[1:0], eff_size_s, eff_uns_s);
    merged_s = store_merge(word_s, eff_wdata_s, eff_addr_s[1:0], eff_size_s);
  end

  // Next-state, latency counter and access strobe
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    access_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          if (LAT_ONE) begin
            state_s  = RESP;
            access_s = 1'b1;
          end else begin
            state_s = WAIT;
            cnt_s   = CNT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s  = RESP;
          access_s = 1'b1;
          cnt_s    = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, request latch and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      size_r       <= 2'd0;
      uns_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);
      if (state_r == IDLE && bus.req_valid) begin
        we_r    <= bus.req_we;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        size_r  <= bus.req_size;
        uns_r   <= bus.req_unsigned;
      end
      if (access_s) begin
        resp_err_r   <= err_s;
        resp_rdata_r <= (err_s || eff_we_s) ? 32'd0 : rdata_s;
      end else if (state_r == RESP && bus.resp_ready) begin
        resp_err_r   <= 1'b0;
        resp_rdata_r <= 32'd0;
      end
    end
  end

  // RAM write port; contents survive reset, a store still in flight is dropped
  always_ff @(posedge clk) begin
    if (!reset && access_s && eff_we_s && !err_s) begin
      mem[idx_s] <= merged_s;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 2, 3) share one
// stimulus bus; a byte-level memory model predicts every response.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  int          sel;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bi [3] ();
  logic        rdy_a [3];
  logic        vld_a [3];
  logic        err_a [3];
  logic [31:0] rd_a  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bi[g].req_valid    = req_valid && (sel == g + 1);
    assign bi[g].req_we       = req_we;
    assign bi[g].req_addr     = req_addr;
    assign bi[g].req_wdata    = req_wdata;
    assign bi[g].req_size     = req_size;
    assign bi[g].req_unsigned = req_unsigned;
    assign bi[g].resp_ready   = resp_ready;
    assign rdy_a[g] = bi[g].req_ready;
    assign vld_a[g] = bi[g].resp_valid;
    assign err_a[g] = bi[g].resp_err;
    assign rd_a[g]  = bi[g].resp_rdata;
    dmem_responder #(.ADDR_W(12), .LATENCY(g + 1)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bi[g])
    );
  end

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;
  always_comb begin
    m_req_ready  = rdy_a[sel-1];
    m_resp_valid = vld_a[sel-1];
    m_resp_err   = err_a[sel-1];
    m_resp_rdata = rd_a[sel-1];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within cycle budget (t=%0t)", nm, $time);
  endtask

  // Reference model: byte-addressed memory keyed per instance
  logic [7:0] mdl [int];

  function automatic void model(input int s, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] sz, input logic un,
                                output logic [31:0] rd, output logic e);
    int     n;
    longint v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e  = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'h0000_4000);
    rd = 32'd0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[s*65536 + int'(a) + i] = 8'(wd >> (8*i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mdl[s*65536 + int'(a) + i]) << (8*i));
      if (!un && n < 4 && ((v >> (8*n - 1)) & 1) == 1) v = v - (longint'(1) << (8*n));
      rd = 32'(v);
    end
  endfunction

  typedef struct {
    logic [31:0] rd;
    logic        e;
  } exp_t;
  exp_t expq [$];

  bit pending = 1'b0;
  int waitcnt = 0;

  // Every cycle: handshake protocol, latency and response data against the model
  always @(negedge clk) begin
    if (rst) begin
      check("reset_req_ready", m_req_ready, 1);
      check("reset_resp_valid", m_resp_valid, 0);
      check("reset_rdata", m_resp_rdata, 0);
      check("reset_err", m_resp_err, 0);
      pending = 1'b0;
    end else if (pending) begin
      waitcnt++;
      check("resp_valid_timing", m_resp_valid, (waitcnt >= sel) ? 1 : 0);
      check("busy_req_ready", m_req_ready, 0);
      if (m_resp_valid) begin
        if (expq.size() == 0) begin
          timeout("unexpected_response");
        end else begin
          check("resp_rdata", m_resp_rdata, expq[0].rd);
          check("resp_err", m_resp_err, expq[0].e);
        end
        if (resp_ready) begin
          if (expq.size() != 0) void'(expq.pop_front());
          pending = 1'b0;
        end
      end
    end else begin
      check("idle_resp_valid", m_resp_valid, 0);
      check("idle_req_ready", m_req_ready, 1);
      if (req_valid) begin
        pending = 1'b1;
        waitcnt = 0;
      end
    end
  end

  // Issue one request at posedge+1, hold the response for bp cycles, return it
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic un, input int bp, input bit hold,
                        output logic [31:0] rd, output logic e, output int acc_at);
    logic [31:0] mr;
    logic        me;
    int          n;
    model(sel, we, a, wd, sz, un, mr, me);
    expq.push_back('{mr, me});
    req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
    req_valid  = 1'b1;
    resp_ready = (bp == 0);
    n = 0;
    while (!m_req_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (n >= 60) timeout("accept");
    @(posedge clk); #1;
    acc_at = cyc;
    if (!hold) req_valid = 1'b0;
    n = 0;
    while (!m_resp_valid && n < 60) begin @(posedge clk); #1; n++; end
    if (n >= 60) timeout("response");
    for (int i = 0; i < bp; i++) begin
      req_addr = req_addr ^ 32'h0000_0F0C; req_wdata = ~req_wdata;
      req_we = ~req_we; req_size = 2'd3; req_unsigned = ~req_unsigned;
      @(posedge clk); #1;
      check("bp_rdata_literal", m_resp_rdata, 32'h1234_AB78);
    end
    resp_ready = 1'b1;
    rd = m_resp_rdata;
    e  = m_resp_err;
    @(posedge clk); #1;
  endtask

  task automatic xt(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input logic un,
                    input logic [31:0] exp_rd, input logic exp_e);
    logic [31:0] rd;
    logic        e;
    int          at;
    do_req(we, a, wd, sz, un, 0, 1'b0, rd, e, at);
    check({nm, "_rdata"}, rd, exp_rd);
    check({nm, "_err"}, e, {31'd0, exp_e});
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          a0, a1, a2;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          a0, a1, a2, a3;
    rst = 1'b1; sel = 2;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=2: word round-trip, lanes, errors
    xt("st_word",    1'b1, 32'h40, 32'h1234_5678, 2'd2, 1'b0, 32'h0, 1'b0);
    xt("ld_word",    1'b0, 32'h40, 32'h0,         2'd2, 1'b0, 32'h1234_5678, 1'b0);
    xt("st_byte",    1'b1, 32'h41, 32'h5555_55AB, 2'd0, 1'b0, 32'h0, 1'b0);
    xt("ld_merged",  1'b0, 32'h40, 32'h0,         2'd2, 1'b0, 32'h1234_AB78, 1'b0);
    xt("ld_byte_s",  1'b0, 32'h41, 32'h0,         2'd0, 1'b0, 32'hFFFF_FFAB, 1'b0);
    xt("ld_byte_u",  1'b0, 32'h41, 32'h0,         2'd0, 1'b1, 32'h0000_00AB, 1'b0);
    xt("ld_half_s",  1'b0, 32'h42, 32'h0,         2'd1, 1'b0, 32'h0000_1234, 1'b0);
    xt("st_half",    1'b1, 32'h46, 32'hAAAA_8001, 2'd1, 1'b0, 32'h0, 1'b0);
    xt("ld_half_neg",1'b0, 32'h46, 32'h0,         2'd1, 1'b0, 32'hFFFF_8001, 1'b0);
    xt("ld_half_u",  1'b0, 32'h46, 32'h0,         2'd1, 1'b1, 32'h0000_8001, 1'b0);
    xt("err_half",   1'b0, 32'h43, 32'h0,         2'd1, 1'b0, 32'h0, 1'b1);
    xt("err_word_st",1'b1, 32'h42, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'h0, 1'b1);
    xt("err_size3",  1'b0, 32'h40, 32'h0,         2'd3, 1'b0, 32'h0, 1'b1);
    xt("err_range",  1'b0, 32'h4000, 32'h0,       2'd2, 1'b0, 32'h0, 1'b1);
    xt("ld_after_err",1'b0, 32'h40, 32'h0,        2'd2, 1'b0, 32'h1234_AB78, 1'b0);

    // Response backpressure with request inputs wiggling
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5, 1'b0, rd, e, a0);
    check("bp_final_rdata", rd, 32'h1234_AB78);

    // LATENCY=3: reset while a store waits
    sel = 3;
    @(posedge clk); #1;
    xt("l3_st_prior", 1'b1, 32'h10, 32'h0BAD_F00D, 2'd2, 1'b0, 32'h0, 1'b0);
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_size = 2'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_now_resp_valid", m_resp_valid, 0);
    check("rst_now_req_ready", m_req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    xt("l3_ld_after_rst", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 1'b0);

    // LATENCY=1: back-to-back accepts with req_valid held high
    sel = 1;
    @(posedge clk); #1;
    xt("l1_st", 1'b1, 32'h80, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 32'h80, 32'h0, 2'd2, 1'b0, 0, 1'b1, rd, e, a0);
    check("l1_ld_word", rd, 32'hCAFE_F00D);
    do_req(1'b0, 32'h83, 32'h0, 2'd0, 1'b1, 0, 1'b1, rd, e, a1);
    check("l1_ld_byte_u", rd, 32'h0000_00CA);
    do_req(1'b0, 32'h80, 32'h0, 2'd1, 1'b0, 0, 1'b1, rd, e, a2);
    check("l1_ld_half_s", rd, 32'hFFFF_F00D);
    do_req(1'b0, 32'h82, 32'h0, 2'd1, 1'b1, 0, 1'b0, rd, e, a3);
    check("l1_ld_half_u", rd, 32'h0000_CAFE);
    check("l1_spacing_0", a1 - a0, 2);
    check("l1_spacing_1", a2 - a1, 2);
    check("l1_spacing_2", a3 - a2, 2);

    repeat (3) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
